// File: rtl/regbus_pkg.sv
// Shared encodings and widths for the register-bus arbiter slice.
package regbus_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] TMO_RDATA = 32'hDEAD_DEAD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/regbus_arb_rr_arb2.sv
// Two-requester round-robin: combinational grant, registered last_grant (resets to 1 so 0 wins first).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  output logic       o_gnt_vld,
  output logic       o_gnt_idx
);
  logic r_last;

  assign o_gnt_vld = |i_req;
  assign o_gnt_idx = (i_req == 2'b11) ? ~r_last : i_req[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (i_upd && o_gnt_vld) begin
      r_last <= o_gnt_idx;
    end
  end
endmodule

// File: rtl/regbus_arb.sv
// Two-master register-bus arbiter, one transaction in flight, with timeout and late-ack drain.
module regbus_arb
  import regbus_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int TW      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              out_req,
  output logic              out_wr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_wdata,
  output logic [STRB_W-1:0] out_wstrb,
  input  logic              out_ack,
  input  logic              out_err,
  input  logic [DATA_W-1:0] out_rdata
);
  localparam logic [TW-1:0] LP_TMAX = TW'(TIMEOUT - 1);

  state_t                   r_state;
  logic [1:0]               r_pend;
  logic                     r_cur;
  logic [TW-1:0]            r_cnt;
  logic [1:0]               r_ack;
  logic [1:0]               r_err;
  logic [1:0][DATA_W-1:0]   r_rdata;
  logic                     r_out_req;
  logic                     r_out_wr;
  logic [ADDR_W-1:0]        r_out_addr;
  logic [DATA_W-1:0]        r_out_wdata;
  logic [STRB_W-1:0]        r_out_wstrb;

  logic [1:0]               w_req_vec;
  logic [1:0]               w_arb_req;
  logic [1:0]               w_pend_nxt;
  logic                     w_gnt_en;
  logic                     w_gnt_idx;
  logic [1:0]               w_wr;
  logic [1:0][ADDR_W-1:0]   w_addr;
  logic [1:0][DATA_W-1:0]   w_wdata;
  logic [1:0][STRB_W-1:0]   w_wstrb;

  assign w_req_vec = {m1_req, m0_req} | r_pend;
  assign w_wr      = {m1_wr, m0_wr};
  assign w_addr    = {m1_addr, m0_addr};
  assign w_wdata   = {m1_wdata, m0_wdata};
  assign w_wstrb   = {m1_wstrb, m0_wstrb};

  // On a slave ack the next grant issues on the same edge; the completing master is
  // masked so it never sees ack and out_req together.
  always_comb begin
    w_arb_req = 2'b00;
    if (r_state == ST_IDLE) begin
      w_arb_req = w_req_vec;
    end else if (r_state == ST_BUSY && out_ack) begin
      w_arb_req = w_req_vec & ~(2'b01 << r_cur);
    end
  end

  rr_arb2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_arb_req),
    .i_upd     (1'b1),
    .o_gnt_vld (w_gnt_en),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_pend_nxt = w_req_vec & ~(w_gnt_en ? (2'b01 << w_gnt_idx) : 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pend      <= '0;
      r_cur       <= 1'b0;
      r_cnt       <= '0;
      r_ack       <= '0;
      r_err       <= '0;
      r_rdata     <= '0;
      r_out_req   <= 1'b0;
      r_out_wr    <= 1'b0;
      r_out_addr  <= '0;
      r_out_wdata <= '0;
      r_out_wstrb <= '0;
    end else begin
      r_ack     <= '0;
      r_err     <= '0;
      r_out_req <= 1'b0;
      r_pend    <= w_pend_nxt;
      case (r_state)
        ST_BUSY: begin
          if (out_ack) begin
            r_ack[r_cur]   <= 1'b1;
            r_err[r_cur]   <= out_err;
            r_rdata[r_cur] <= out_rdata;
            r_state        <= ST_IDLE;
          end else if (r_cnt == LP_TMAX) begin
            r_ack[r_cur]   <= 1'b1;
            r_err[r_cur]   <= 1'b1;
            r_rdata[r_cur] <= TMO_RDATA;
            r_cnt          <= '0;
            r_state        <= ST_DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (out_ack || r_cnt == LP_TMAX) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_gnt_en) begin
        r_out_req   <= 1'b1;
        r_out_wr    <= w_wr[w_gnt_idx];
        r_out_addr  <= w_addr[w_gnt_idx];
        r_out_wdata <= w_wdata[w_gnt_idx];
        r_out_wstrb <= w_wstrb[w_gnt_idx];
        r_cur       <= w_gnt_idx;
        r_cnt       <= '0;
        r_state     <= ST_BUSY;
      end
    end
  end

  assign m0_ack    = r_ack[0];
  assign m0_err    = r_err[0];
  assign m0_rdata  = r_rdata[0];
  assign m1_ack    = r_ack[1];
  assign m1_err    = r_err[1];
  assign m1_rdata  = r_rdata[1];
  assign out_req   = r_out_req;
  assign out_wr    = r_out_wr;
  assign out_addr  = r_out_addr;
  assign out_wdata = r_out_wdata;
  assign out_wstrb = r_out_wstrb;
endmodule

// File: tb/tb_regbus_arb.sv
// Directed bench for regbus_arb with TIMEOUT = 8; inputs change and outputs are checked 1 time unit after posedge.
module tb_regbus_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        out_req, out_wr;
  logic [31:0] out_addr, out_wdata;
  logic [3:0]  out_wstrb;
  logic        out_ack, out_err;
  logic [31:0] out_rdata;

  int n_cmp = 0;
  int n_err = 0;

  regbus_arb #(.TIMEOUT(8), .TW(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .out_req(out_req), .out_wr(out_wr), .out_addr(out_addr), .out_wdata(out_wdata),
    .out_wstrb(out_wstrb), .out_ack(out_ack), .out_err(out_err), .out_rdata(out_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic slave_ack(input logic err, input logic [31:0] rd);
    out_ack = 1'b1; out_err = err; out_rdata = rd;
  endtask

  task automatic slave_idle();
    out_ack = 1'b0; out_err = 1'b0; out_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    m0_req = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_req = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    slave_idle();
    rst = 1'b1;
    #1;
    tick();
    chk("rst_outs", {31'd0, out_req | m0_ack | m1_ack | m0_err | m1_err | out_wr}, 32'd0);
    chk("rst_addr", out_addr, 32'd0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    do_reset();

    // simultaneous pair from reset: m0 first, m1 granted on the m0 ack edge
    m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_addr = 32'h20;
    tick();
    m0_req = 0; m1_req = 0;
    chk("pairA_req0", {31'd0, out_req}, 32'd1);
    chk("pairA_addr0", out_addr, 32'h10);
    slave_ack(1'b0, 32'h0000_000A);
    tick();
    slave_idle();
    chk("pairA_ack0", {30'd0, m1_ack, m0_ack}, 32'b01);
    chk("pairA_rd0", m0_rdata, 32'h0000_000A);
    chk("b2b_req1", {31'd0, out_req}, 32'd1);
    chk("b2b_addr1", out_addr, 32'h20);
    tick();
    chk("pairA_quiet", {29'd0, out_req, m1_ack, m0_ack}, 32'd0);
    slave_ack(1'b0, 32'h0000_000B);
    tick();
    slave_idle();
    chk("pairA_ack1", {30'd0, m1_ack, m0_ack}, 32'b10);
    chk("pairA_rd1", m1_rdata, 32'h0000_000B);
    tick();
    chk("pairA_done", {29'd0, out_req, m1_ack, m0_ack}, 32'd0);

    // single read from m0, slave answers 3 cycles after out_req
    m0_req = 1; m0_wr = 0; m0_addr = 32'h0000_0104;
    tick();
    m0_req = 0;
    chk("rd_req", {31'd0, out_req}, 32'd1);
    chk("rd_addr", out_addr, 32'h0000_0104);
    chk("rd_wr", {31'd0, out_wr}, 32'd0);
    tick();
    chk("rd_req_pulse", {31'd0, out_req}, 32'd0);
    tick();
    tick();
    slave_ack(1'b0, 32'h1234_5678);
    tick();
    slave_idle();
    chk("rd_ack", {30'd0, m1_ack, m0_ack}, 32'b01);
    chk("rd_rdata", m0_rdata, 32'h1234_5678);
    chk("rd_err", {31'd0, m0_err}, 32'd0);
    tick();
    chk("rd_ack_pulse", {30'd0, m1_ack, m0_ack}, 32'd0);

    // second pair: last grant was m0, so m1 goes first
    m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_addr = 32'h20;
    tick();
    m0_req = 0; m1_req = 0;
    chk("pairB_addr0", out_addr, 32'h20);
    slave_ack(1'b0, 32'h0000_000C);
    tick();
    slave_idle();
    chk("pairB_ack0", {30'd0, m1_ack, m0_ack}, 32'b10);
    chk("pairB_rd0", m1_rdata, 32'h0000_000C);
    chk("pairB_addr1", out_addr, 32'h10);
    tick();
    slave_ack(1'b0, 32'h0000_000D);
    tick();
    slave_idle();
    chk("pairB_ack1", {30'd0, m1_ack, m0_ack}, 32'b01);
    chk("pairB_rd1", m0_rdata, 32'h0000_000D);
    tick();

    // write from m1 with slave error
    m1_req = 1; m1_wr = 1; m1_addr = 32'h30; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0011;
    tick();
    m1_req = 0;
    chk("wr_req", {31'd0, out_req}, 32'd1);
    chk("wr_fields", {out_wr, 27'd0, out_wstrb}, {1'b1, 27'd0, 4'b0011});
    chk("wr_wdata", out_wdata, 32'hAABB_CCDD);
    tick();
    tick();
    chk("wr_stable", out_wdata, 32'hAABB_CCDD);
    chk("wr_stable_s", {27'd0, out_wr, out_wstrb}, {27'd0, 1'b1, 4'b0011});
    slave_ack(1'b1, 32'h0);
    tick();
    slave_idle();
    chk("wr_ack", {30'd0, m1_ack, m0_ack}, 32'b10);
    chk("wr_err", {31'd0, m1_err}, 32'd1);
    tick();
    m1_wr = 0;

    // timeout on m0 with m1 pending, late ack swallowed in drain
    m0_req = 1; m0_addr = 32'h40;
    tick();
    m0_req = 0;
    chk("to_req", {31'd0, out_req}, 32'd1);
    m1_req = 1; m1_addr = 32'h50;
    tick();
    m1_req = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("to_early", {29'd0, out_req, m1_ack, m0_ack}, 32'd0);
    tick();
    chk("to_ack", {30'd0, m1_ack, m0_ack}, 32'b01);
    chk("to_err", {31'd0, m0_err}, 32'd1);
    chk("to_rdata", m0_rdata, 32'hDEAD_DEAD);
    tick();
    tick();
    chk("drain_nogrant", {29'd0, out_req, m1_ack, m0_ack}, 32'd0);
    tick();
    slave_ack(1'b0, 32'h7777_7777);
    tick();
    slave_idle();
    chk("late_ack_swallowed", {29'd0, out_req, m1_ack, m0_ack}, 32'd0);
    tick();
    chk("post_drain_req", {31'd0, out_req}, 32'd1);
    chk("post_drain_addr", out_addr, 32'h50);
    slave_ack(1'b0, 32'h0000_0055);
    tick();
    slave_idle();
    chk("post_drain_ack", {30'd0, m1_ack, m0_ack}, 32'b10);
    chk("post_drain_rd", m1_rdata, 32'h0000_0055);
    tick();

    // reset mid-transaction with m1 pending
    m0_req = 1; m0_addr = 32'h60;
    tick();
    m0_req = 0;
    m1_req = 1; m1_addr = 32'h70;
    tick();
    m1_req = 0;
    chk("pre_rst_addr", out_addr, 32'h60);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_addr", out_addr, 32'd0);
    chk("async_rst_outs", {30'd0, out_req, out_wr}, 32'd0);
    tick();
    rst = 1'b0;
    slave_ack(1'b0, 32'h1111_1111);
    tick();
    slave_idle();
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_quiet", {29'd0, out_req, m1_ack, m0_ack}, 32'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
